// File: rtl/bi_serial_loader.sv
// MSB-first serial-to-parallel word loader with valid/ready hold and malformed-frame flagging.
// Optional trailing even-parity bit per frame when BI_LOADER_PARITY_EN is defined.
module bi_serial_loader #(
    parameter int WORD_W      = 12,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sin_start,
    input  logic              sin_valid,
    input  logic              sin_data,
    output logic [WORD_W-1:0] bi_out,
    output logic              bi_valid,
    input  logic              bi_ready,
    output logic              frame_err,
    output logic              busy
);

`ifdef BI_LOADER_PARITY_EN
    localparam int FRAME_W = WORD_W + 1;
`else
    localparam int FRAME_W = WORD_W;
`endif
    // The shift register holds every frame bit except the one being sampled last.
    localparam int SR_W  = FRAME_W - 1;
    localparam int CNT_W = $clog2(WORD_W + 2);
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_W - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TIMEOUT_CYC);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        HOLD
    } stateT;

    stateT             state, stateNext;
    logic [SR_W-1:0]   sr, srNext;
    logic [CNT_W-1:0]  bitCnt, bitCntNext;
    logic [TMO_W-1:0]  tmoCnt, tmoCntNext;
    logic [WORD_W-1:0] outNext;
    logic              validNext;
    logic              errNext;
    logic [SR_W-1:0]   srShifted;

    assign srShifted = {sr[SR_W-2:0], sin_data};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            sr        <= '0;
            bitCnt    <= '0;
            tmoCnt    <= '0;
            bi_out    <= '0;
            bi_valid  <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= stateNext;
            sr        <= srNext;
            bitCnt    <= bitCntNext;
            tmoCnt    <= tmoCntNext;
            bi_out    <= outNext;
            bi_valid  <= validNext;
            frame_err <= errNext;
            busy      <= (stateNext != IDLE);
        end
    end

    always_comb begin
        stateNext  = state;
        srNext     = sr;
        bitCntNext = bitCnt;
        tmoCntNext = tmoCnt;
        outNext    = bi_out;
        validNext  = bi_valid;
        errNext    = 1'b0;

        case (state)
            IDLE: begin
                if (sin_start) begin
                    stateNext  = SHIFT;
                    srNext     = '0;
                    bitCntNext = '0;
                    tmoCntNext = '0;
                end
            end

            SHIFT: begin
                // A new start aborts the partial frame and begins a fresh one.
                if (sin_start) begin
                    errNext    = 1'b1;
                    srNext     = '0;
                    bitCntNext = '0;
                    tmoCntNext = '0;
                end else if (sin_valid) begin
                    tmoCntNext = '0;
                    bitCntNext = bitCnt + CNT_W'(1);
                    if (bitCnt == LAST_BIT) begin
`ifdef BI_LOADER_PARITY_EN
                        if ((^sr) ^ sin_data) begin
                            errNext   = 1'b1;
                            stateNext = IDLE;
                        end else begin
                            stateNext = HOLD;
                            outNext   = sr;
                            validNext = 1'b1;
                        end
`else
                        stateNext = HOLD;
                        outNext   = {sr, sin_data};
                        validNext = 1'b1;
`endif
                    end else begin
                        srNext = srShifted;
                    end
                end else if (tmoCnt >= TMO_LAST) begin
                    errNext    = 1'b1;
                    stateNext  = IDLE;
                    tmoCntNext = TMO_MAX;
                end else begin
                    tmoCntNext = tmoCnt + TMO_W'(1);
                end
            end

            HOLD: begin
                // A start coinciding with the handshake chains straight into the next frame.
                if (bi_valid && bi_ready) begin
                    validNext = 1'b0;
                    if (sin_start) begin
                        stateNext  = SHIFT;
                        srNext     = '0;
                        bitCntNext = '0;
                        tmoCntNext = '0;
                    end else begin
                        stateNext = IDLE;
                    end
                end else if (sin_start) begin
                    errNext = 1'b1;
                end
            end

            default: begin
                stateNext = IDLE;
                validNext = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_bi_serial_loader.sv
// Directed self-checking bench for bi_serial_loader; define BI_LOADER_PARITY_EN to also cover parity frames.
module tb_bi_serial_loader;

    localparam int WORD_W = 12;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              sin_start = 1'b0;
    logic              sin_valid = 1'b0;
    logic              sin_data = 1'b0;
    logic [WORD_W-1:0] bi_out;
    logic              bi_valid;
    logic              bi_ready = 1'b0;
    logic              frame_err;
    logic              busy;

    int passCnt  = 0;
    int totalCnt = 0;
    int errCount = 0;
    bit validSeen = 1'b0;

    bi_serial_loader #(.WORD_W(WORD_W), .TIMEOUT_CYC(255)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .sin_start(sin_start),
        .sin_valid(sin_valid),
        .sin_data(sin_data),
        .bi_out(bi_out),
        .bi_valid(bi_valid),
        .bi_ready(bi_ready),
        .frame_err(frame_err),
        .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_err) errCount++;
        if (bi_valid) validSeen = 1'b1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sendStart();
        sin_start = 1'b1;
        tick();
        sin_start = 1'b0;
    endtask

    task automatic sendBit(input logic b);
        sin_valid = 1'b1;
        sin_data  = b;
        tick();
        sin_valid = 1'b0;
        sin_data  = 1'b0;
    endtask

    task automatic sendIdle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic sendBits(input logic [WORD_W-1:0] w, input int gap);
        for (int i = WORD_W - 1; i >= 0; i--) begin
            sendBit(w[i]);
`ifndef BI_LOADER_PARITY_EN
            if (i != 0) sendIdle(gap);
`else
            sendIdle(gap);
`endif
        end
`ifdef BI_LOADER_PARITY_EN
        sendBit(^w);
`endif
    endtask

    task automatic accept();
        bi_ready = 1'b1;
        tick();
        bi_ready = 1'b0;
    endtask

    task automatic test_reset();
        totalCnt++; if (bi_out !== 12'h000) $display("FAIL reset_bi_out actual=%h required=000", bi_out); else passCnt++;
        totalCnt++; if (bi_valid !== 1'b0) $display("FAIL reset_bi_valid actual=%b required=0", bi_valid); else passCnt++;
        totalCnt++; if (frame_err !== 1'b0) $display("FAIL reset_frame_err actual=%b required=0", frame_err); else passCnt++;
        totalCnt++; if (busy !== 1'b0) $display("FAIL reset_busy actual=%b required=0", busy); else passCnt++;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_hold();
        sendStart();
        totalCnt++; if (busy !== 1'b1) $display("FAIL hold_busy_start actual=%b required=1", busy); else passCnt++;
        sendBits(12'h800, 0);
        totalCnt++; if (bi_valid !== 1'b1) $display("FAIL hold_valid actual=%b required=1", bi_valid); else passCnt++;
        totalCnt++; if (bi_out !== 12'h800) $display("FAIL hold_word actual=%h required=800", bi_out); else passCnt++;
        for (int i = 0; i < 5; i++) begin
            tick();
            totalCnt++; if (bi_out !== 12'h800 || bi_valid !== 1'b1)
                $display("FAIL hold_stable cycle=%0d actual=%h/%b required=800/1", i, bi_out, bi_valid); else passCnt++;
        end
        accept();
        totalCnt++; if (bi_valid !== 1'b0) $display("FAIL hold_release_valid actual=%b required=0", bi_valid); else passCnt++;
        totalCnt++; if (busy !== 1'b0) $display("FAIL hold_release_busy actual=%b required=0", busy); else passCnt++;
        totalCnt++; if (bi_out !== 12'h800) $display("FAIL hold_keep_word actual=%h required=800", bi_out); else passCnt++;
    endtask

    task automatic test_reset_mid_shift();
        logic [WORD_W-1:0] w;
        w = 12'h5A5;
        sendStart();
        for (int i = WORD_W - 1; i >= WORD_W - 6; i--) sendBit(w[i]);
        #2;
        rst_n = 1'b0;
        #1;
        totalCnt++; if (bi_out !== 12'h000) $display("FAIL midrst_bi_out actual=%h required=000", bi_out); else passCnt++;
        totalCnt++; if (bi_valid !== 1'b0) $display("FAIL midrst_bi_valid actual=%b required=0", bi_valid); else passCnt++;
        totalCnt++; if (busy !== 1'b0) $display("FAIL midrst_busy actual=%b required=0", busy); else passCnt++;
        totalCnt++; if (frame_err !== 1'b0) $display("FAIL midrst_frame_err actual=%b required=0", frame_err); else passCnt++;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        sendStart();
        sendBits(w, 0);
        totalCnt++; if (bi_out !== 12'h5A5) $display("FAIL midrst_recapture actual=%h required=5a5", bi_out); else passCnt++;
        totalCnt++; if (bi_valid !== 1'b1) $display("FAIL midrst_recapture_valid actual=%b required=1", bi_valid); else passCnt++;
        accept();
    endtask

    task automatic test_slow_bits();
        int errBase;
        errBase = errCount;
        sendStart();
        sendBits(12'h7FF, 3);
        totalCnt++; if (bi_out !== 12'h7FF) $display("FAIL slow_word actual=%h required=7ff", bi_out); else passCnt++;
        totalCnt++; if (bi_valid !== 1'b1) $display("FAIL slow_valid actual=%b required=1", bi_valid); else passCnt++;
        totalCnt++; if (errCount !== errBase) $display("FAIL slow_no_err actual=%0d required=%0d", errCount, errBase); else passCnt++;
        accept();
    endtask

    task automatic test_timeout();
        int errBase;
        errBase = errCount;
        validSeen = 1'b0;
        sendStart();
        for (int i = 0; i < 5; i++) sendBit(i[0]);
        sendIdle(254);
        totalCnt++; if (frame_err !== 1'b0 || busy !== 1'b1)
            $display("FAIL tmo_early actual=%b/%b required=0/1", frame_err, busy); else passCnt++;
        tick();
        totalCnt++; if (frame_err !== 1'b1) $display("FAIL tmo_pulse actual=%b required=1", frame_err); else passCnt++;
        totalCnt++; if (busy !== 1'b0) $display("FAIL tmo_busy actual=%b required=0", busy); else passCnt++;
        tick();
        totalCnt++; if (frame_err !== 1'b0) $display("FAIL tmo_pulse_width actual=%b required=0", frame_err); else passCnt++;
        sendIdle(3);
        totalCnt++; if (errCount - errBase !== 1) $display("FAIL tmo_err_count actual=%0d required=1", errCount - errBase); else passCnt++;
        totalCnt++; if (validSeen !== 1'b0) $display("FAIL tmo_valid_seen actual=%b required=0", validSeen); else passCnt++;
    endtask

    task automatic test_back_to_back();
        sendStart();
        sendBits(12'hABC, 0);
        totalCnt++; if (bi_out !== 12'hABC) $display("FAIL b2b_first_word actual=%h required=abc", bi_out); else passCnt++;
        sendStart();
        totalCnt++; if (frame_err !== 1'b1) $display("FAIL b2b_hold_start_err actual=%b required=1", frame_err); else passCnt++;
        totalCnt++; if (bi_out !== 12'hABC) $display("FAIL b2b_hold_word actual=%h required=abc", bi_out); else passCnt++;
        bi_ready  = 1'b1;
        sin_start = 1'b1;
        tick();
        bi_ready  = 1'b0;
        sin_start = 1'b0;
        totalCnt++; if (bi_valid !== 1'b0) $display("FAIL b2b_handshake_valid actual=%b required=0", bi_valid); else passCnt++;
        totalCnt++; if (busy !== 1'b1) $display("FAIL b2b_busy actual=%b required=1", busy); else passCnt++;
        totalCnt++; if (frame_err !== 1'b0) $display("FAIL b2b_no_err actual=%b required=0", frame_err); else passCnt++;
        sendBits(12'h001, 0);
        totalCnt++; if (bi_out !== 12'h001) $display("FAIL b2b_second_word actual=%h required=001", bi_out); else passCnt++;
        totalCnt++; if (bi_valid !== 1'b1) $display("FAIL b2b_second_valid actual=%b required=1", bi_valid); else passCnt++;
        accept();
    endtask

    task automatic test_restart_in_shift();
        sendStart();
        sendBit(1'b1);
        sendBit(1'b1);
        sin_valid = 1'b1;
        sin_data  = 1'b1;
        sendStart();
        sin_valid = 1'b0;
        sin_data  = 1'b0;
        totalCnt++; if (frame_err !== 1'b1 || busy !== 1'b1)
            $display("FAIL restart_err actual=%b/%b required=1/1", frame_err, busy); else passCnt++;
        sendBits(12'h123, 1);
        totalCnt++; if (bi_out !== 12'h123) $display("FAIL restart_word actual=%h required=123", bi_out); else passCnt++;
        accept();
    endtask

`ifdef BI_LOADER_PARITY_EN
    task automatic test_parity();
        logic [WORD_W-1:0] w;
        w = 12'h001;
        sendStart();
        for (int i = WORD_W - 1; i >= 0; i--) sendBit(w[i]);
        sendBit(1'b1);
        totalCnt++; if (bi_valid !== 1'b1) $display("FAIL par_good_valid actual=%b required=1", bi_valid); else passCnt++;
        totalCnt++; if (bi_out !== 12'h001) $display("FAIL par_good_word actual=%h required=001", bi_out); else passCnt++;
        accept();
        sendStart();
        for (int i = WORD_W - 1; i >= 0; i--) sendBit(w[i] ^ (i == 4));
        sendBit(1'b1);
        totalCnt++; if (frame_err !== 1'b1) $display("FAIL par_bad_err actual=%b required=1", frame_err); else passCnt++;
        totalCnt++; if (bi_valid !== 1'b0) $display("FAIL par_bad_valid actual=%b required=0", bi_valid); else passCnt++;
        totalCnt++; if (bi_out !== 12'h001) $display("FAIL par_bad_word actual=%h required=001", bi_out); else passCnt++;
        sendStart();
        for (int i = WORD_W - 1; i >= 0; i--) sendBit(w[i]);
        sendBit(1'b0);
        totalCnt++; if (frame_err !== 1'b1) $display("FAIL par_zero_err actual=%b required=1", frame_err); else passCnt++;
        totalCnt++; if (bi_valid !== 1'b0 || busy !== 1'b0)
            $display("FAIL par_zero_state actual=%b/%b required=0/0", bi_valid, busy); else passCnt++;
    endtask
`endif

    initial begin
        #3;
        test_reset();
        test_hold();
        test_reset_mid_shift();
        test_slow_bits();
        test_timeout();
        test_back_to_back();
        test_restart_in_shift();
`ifdef BI_LOADER_PARITY_EN
        test_parity();
`endif
        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
